// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched instructions until both operands
// are resolved from the CDBs, then issues the lowest-index ready entry per cycle.
module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear,
    input  logic               dispatch_enable,
    input  logic [5:0]         dispatch_op,
    input  logic [31:0]        dispatch_imm,
    input  logic [31:0]        dispatch_pc,
    input  logic               dispatch_reg1_valid,
    input  logic [31:0]        dispatch_reg1_data,
    input  logic [TAG_W-1:0]   dispatch_reg1_tag,
    input  logic               dispatch_reg2_valid,
    input  logic [31:0]        dispatch_reg2_data,
    input  logic [TAG_W-1:0]   dispatch_reg2_tag,
    input  logic [TAG_W-1:0]   dispatch_reg_dest_tag,
    input  logic               cdb_alu_valid,
    input  logic [TAG_W-1:0]   cdb_alu_tag,
    input  logic [31:0]        cdb_alu_data,
    input  logic               cdb_lsb_valid,
    input  logic [TAG_W-1:0]   cdb_lsb_tag,
    input  logic [31:0]        cdb_lsb_data,
    output logic               rs_full,
    output logic               alu_enable,
    output logic [5:0]         alu_op,
    output logic [31:0]        alu_imm,
    output logic [31:0]        alu_pc,
    output logic [31:0]        alu_reg1_data,
    output logic [31:0]        alu_reg2_data,
    output logic [TAG_W-1:0]   alu_reg_dest_tag
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic              valid;
        logic [31:0]       data;
        logic [TAG_W-1:0]  tag;
    } operand_t;

    // Tag 0 means "no producer" and must never be woken by a broadcast.
    function automatic logic cdb_hit(input logic bus_valid, input logic [TAG_W-1:0] bus_tag,
                                     input logic [TAG_W-1:0] wait_tag);
        return bus_valid && (bus_tag != {TAG_W{1'b0}}) && (bus_tag == wait_tag);
    endfunction

    // Shared by dispatch forwarding and snooping; the ALU bus wins on equal tags.
    function automatic operand_t resolve_operand(
        input operand_t cur,
        input logic a_valid, input logic [TAG_W-1:0] a_tag, input logic [31:0] a_data,
        input logic l_valid, input logic [TAG_W-1:0] l_tag, input logic [31:0] l_data);
        operand_t res;
        res = cur;
        if (!cur.valid && cdb_hit(a_valid, a_tag, cur.tag)) begin
            res = '{valid: 1'b1, data: a_data, tag: {TAG_W{1'b0}}};
        end else if (!cur.valid && cdb_hit(l_valid, l_tag, cur.tag)) begin
            res = '{valid: 1'b1, data: l_data, tag: {TAG_W{1'b0}}};
        end else begin
            res = cur;
        end
        return res;
    endfunction

    logic [RS_SIZE-1:0] busy_r;
    logic [5:0]         op_r    [RS_SIZE];
    logic [31:0]        imm_r   [RS_SIZE];
    logic [31:0]        pc_r    [RS_SIZE];
    logic [TAG_W-1:0]   dest_r  [RS_SIZE];
    operand_t           opnd1_r [RS_SIZE];
    operand_t           opnd2_r [RS_SIZE];

    logic               alu_enable_r;
    logic [5:0]         alu_op_r;
    logic [31:0]        alu_imm_r;
    logic [31:0]        alu_pc_r;
    logic [31:0]        alu_reg1_data_r;
    logic [31:0]        alu_reg2_data_r;
    logic [TAG_W-1:0]   alu_reg_dest_tag_r;

    logic               free_found_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic               issue_found_s;
    logic [IDX_W-1:0]   issue_idx_s;
    operand_t           disp_opnd1_s;
    operand_t           disp_opnd2_s;

    // Lowest-index free and ready entries, both from start-of-cycle state.
    always_comb begin
        free_found_s  = 1'b0;
        free_idx_s    = {IDX_W{1'b0}};
        issue_found_s = 1'b0;
        issue_idx_s   = {IDX_W{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            free_found_s  = !busy_r[i] ? 1'b1 : free_found_s;
            free_idx_s    = !busy_r[i] ? IDX_W'(i) : free_idx_s;
            issue_found_s = (busy_r[i] && opnd1_r[i].valid && opnd2_r[i].valid) ? 1'b1 : issue_found_s;
            issue_idx_s   = (busy_r[i] && opnd1_r[i].valid && opnd2_r[i].valid) ? IDX_W'(i) : issue_idx_s;
        end
    end

    // Dispatched operands, with same-cycle CDB forwarding.
    always_comb begin
        disp_opnd1_s = resolve_operand('{valid: dispatch_reg1_valid, data: dispatch_reg1_data, tag: dispatch_reg1_tag},
                                       cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                                       cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
        disp_opnd2_s = resolve_operand('{valid: dispatch_reg2_valid, data: dispatch_reg2_data, tag: dispatch_reg2_tag},
                                       cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                                       cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
    end

    // Entry storage, snoop, allocation and issue register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_r             <= {RS_SIZE{1'b0}};
            alu_enable_r       <= 1'b0;
            alu_op_r           <= 6'd0;
            alu_imm_r          <= 32'd0;
            alu_pc_r           <= 32'd0;
            alu_reg1_data_r    <= 32'd0;
            alu_reg2_data_r    <= 32'd0;
            alu_reg_dest_tag_r <= {TAG_W{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                op_r[i]    <= 6'd0;
                imm_r[i]   <= 32'd0;
                pc_r[i]    <= 32'd0;
                dest_r[i]  <= {TAG_W{1'b0}};
                opnd1_r[i] <= '0;
                opnd2_r[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                busy_r       <= {RS_SIZE{1'b0}};
                alu_enable_r <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_r[i]) begin
                        opnd1_r[i] <= resolve_operand(opnd1_r[i], cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                                                      cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
                        opnd2_r[i] <= resolve_operand(opnd2_r[i], cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
                                                      cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_data);
                    end
                    if (issue_found_s && (issue_idx_s == IDX_W'(i))) begin
                        busy_r[i] <= 1'b0;
                    end
                    // A free entry is never the issuing one, so the two writes cannot collide.
                    if (dispatch_enable && free_found_s && (free_idx_s == IDX_W'(i))) begin
                        busy_r[i]  <= 1'b1;
                        op_r[i]    <= dispatch_op;
                        imm_r[i]   <= dispatch_imm;
                        pc_r[i]    <= dispatch_pc;
                        dest_r[i]  <= dispatch_reg_dest_tag;
                        opnd1_r[i] <= disp_opnd1_s;
                        opnd2_r[i] <= disp_opnd2_s;
                    end
                end
                if (issue_found_s) begin
                    alu_enable_r       <= 1'b1;
                    alu_op_r           <= op_r[issue_idx_s];
                    alu_imm_r          <= imm_r[issue_idx_s];
                    alu_pc_r           <= pc_r[issue_idx_s];
                    alu_reg1_data_r    <= opnd1_r[issue_idx_s].data;
                    alu_reg2_data_r    <= opnd2_r[issue_idx_s].data;
                    alu_reg_dest_tag_r <= dest_r[issue_idx_s];
                end else begin
                    alu_enable_r <= 1'b0;
                end
            end
        end
    end

    assign rs_full          = &busy_r;
    assign alu_enable       = alu_enable_r;
    assign alu_op           = alu_op_r;
    assign alu_imm          = alu_imm_r;
    assign alu_pc           = alu_pc_r;
    assign alu_reg1_data    = alu_reg1_data_r;
    assign alu_reg2_data    = alu_reg2_data_r;
    assign alu_reg_dest_tag = alu_reg_dest_tag_r;

endmodule
